// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolver: decides taken/not-taken, redirects the PC and flushes the wrong path with zero latency.
// A post-redirect shadow window ignores EX inputs; saturating statistics and a sticky illegal-funct3 flag are kept.
module branch_redirect_ctrl #(
  parameter int unsigned SHADOW_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic [31:0]      ex_target,
  input  logic             stall,
  input  logic             cnt_clr,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             illegal_br,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {IDLE = 1'b0, SHADOW = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       shadow_q, shadow_d;
  logic             illegal_q;
  logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;

  logic cond;
  logic f3_illegal;
  logic eval;
  logic taken;

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = alu_zero;
      3'b001:  cond = !alu_zero;
      3'b100:  cond = alu_lt;
      3'b101:  cond = !alu_lt;
      3'b110:  cond = alu_ltu;
      3'b111:  cond = !alu_ltu;
      default: cond = 1'b0;
    endcase
  end

  assign f3_illegal = (ex_funct3[2:1] == 2'b01);
  // Gating with rst_n keeps the redirect outputs quiet while reset is asserted.
  assign eval       = rst_n && (state_q == IDLE) && ex_valid && ex_branch && !stall;
  assign taken      = eval && cond;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (taken) begin
          state_d  = SHADOW;
          shadow_d = 3'(SHADOW_CYCLES);
        end
      end
      SHADOW: begin
        // The window only advances on cycles where the pipeline actually moves.
        if (!stall) begin
          shadow_d = shadow_q - 3'd1;
          if (shadow_q <= 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_sel     = taken;
    flush_ifid = taken;
    flush_idex = taken;
    pc_target  = taken ? ex_target : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q    <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      if (eval && f3_illegal) illegal_q <= 1'b1;
      if (cnt_clr) begin
        branch_cnt_q <= '0;
        taken_cnt_q  <= '0;
      end else begin
        if (eval && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        if (taken && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
    end
  end

  assign illegal_br = illegal_q;
  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (short window/narrow counters, long window/wide counters)
// driven in lockstep and compared every cycle against a behavioural model.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_branch, stall, cnt_clr;
  logic [2:0]  ex_funct3;
  logic [31:0] op_a, op_b, ex_target;
  logic        alu_zero, alu_lt, alu_ltu;

  logic        pc_sel_w [2];
  logic [31:0] pc_target_w [2];
  logic        flush_ifid_w [2];
  logic        flush_idex_w [2];
  logic        illegal_w [2];
  logic [3:0]  bc0, tc0;
  logic [15:0] bc1, tc1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: remaining ignored cycles, counts, sticky flag.
  int left [2];
  int bcnt [2];
  int tcnt [2];
  bit ill  [2];
  int sh_len [2] = '{1, 3};
  int cmax   [2] = '{15, 65535};

  always #5 clk = ~clk;

  assign alu_zero = (op_a == op_b);
  assign alu_lt   = ($signed(op_a) < $signed(op_b));
  assign alu_ltu  = (op_a < op_b);

  branch_redirect_ctrl #(.SHADOW_CYCLES(1), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .ex_target(ex_target), .stall(stall), .cnt_clr(cnt_clr),
    .pc_sel(pc_sel_w[0]), .pc_target(pc_target_w[0]), .flush_ifid(flush_ifid_w[0]),
    .flush_idex(flush_idex_w[0]), .illegal_br(illegal_w[0]),
    .branch_cnt(bc0), .taken_cnt(tc0)
  );

  branch_redirect_ctrl #(.SHADOW_CYCLES(3), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .ex_target(ex_target), .stall(stall), .cnt_clr(cnt_clr),
    .pc_sel(pc_sel_w[1]), .pc_target(pc_target_w[1]), .flush_ifid(flush_ifid_w[1]),
    .flush_idex(flush_idex_w[1]), .illegal_br(illegal_w[1]),
    .branch_cnt(bc1), .taken_cnt(tc1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] obs_bcnt(input int i);
    return (i == 0) ? 32'(bc0) : 32'(bc1);
  endfunction

  function automatic logic [31:0] obs_tcnt(input int i);
    return (i == 0) ? 32'(tc0) : 32'(tc1);
  endfunction

  // One clock cycle: drive, check combinational and registered outputs mid-cycle, advance the model at the edge.
  task automatic cyc(input bit v, input bit br, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] tgt, input bit st, input bit clr, input bit rn);
    bit ev [2];
    bit tk [2];
    ex_valid = v; ex_branch = br; ex_funct3 = f; op_a = a; op_b = b;
    ex_target = tgt; stall = st; cnt_clr = clr; rst_n = rn;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ev[i] = rn && (left[i] == 0) && v && br && !st;
      tk[i] = ev[i] && ref_taken(f, a, b);
      check($sformatf("u%0d pc_sel", i),     32'(pc_sel_w[i]),     32'(tk[i]));
      check($sformatf("u%0d pc_target", i),  pc_target_w[i],      tk[i] ? tgt : 32'd0);
      check($sformatf("u%0d flush_ifid", i), 32'(flush_ifid_w[i]), 32'(tk[i]));
      check($sformatf("u%0d flush_idex", i), 32'(flush_idex_w[i]), 32'(tk[i]));
      check($sformatf("u%0d illegal_br", i), 32'(illegal_w[i]),    32'(ill[i]));
      check($sformatf("u%0d branch_cnt", i), obs_bcnt(i),          32'(bcnt[i]));
      check($sformatf("u%0d taken_cnt", i),  obs_tcnt(i),          32'(tcnt[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rn) begin
        left[i] = 0; bcnt[i] = 0; tcnt[i] = 0; ill[i] = 1'b0;
      end else begin
        if (left[i] > 0 && !st) left[i]--;
        if (tk[i]) left[i] = sh_len[i];
        if (ev[i] && (f == 3'b010 || f == 3'b011)) ill[i] = 1'b1;
        if (clr) begin
          bcnt[i] = 0; tcnt[i] = 0;
        end else begin
          if (ev[i] && bcnt[i] < cmax[i]) bcnt[i]++;
          if (tk[i] && tcnt[i] < cmax[i]) tcnt[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 3'd0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; bcnt[i] = 0; tcnt[i] = 0; ill[i] = 1'b0;
    end
    ex_valid = 0; ex_branch = 0; ex_funct3 = 0; op_a = 0; op_b = 0;
    ex_target = 0; stall = 0; cnt_clr = 0; rst_n = 0;
    @(posedge clk); #1;
    cyc(1, 1, 3'd1, 1, 2, 32'h44, 0, 0, 0);      // branch under reset: outputs held low

    // BNE taken, zero-latency redirect
    cyc(1, 1, 3'b001, 5, 6, 32'h0000_0100, 0, 0, 1);
    check("bne taken_cnt u0", 32'(tc0), 32'd1);
    idle(4);

    // BGE not taken, then BEQ taken immediately after
    cyc(1, 1, 3'b101, 32'hFFFF_FFFF, 1, 32'h200, 0, 0, 1);
    cyc(1, 1, 3'b000, 7, 7, 32'h300, 0, 0, 1);
    idle(4);

    // Taken BEQ followed by branches held in the shadow window
    cyc(1, 1, 3'b000, 3, 3, 32'h400, 0, 0, 1);
    cyc(1, 1, 3'b000, 3, 3, 32'h404, 0, 0, 1);
    cyc(1, 1, 3'b000, 3, 3, 32'h408, 0, 0, 1);
    cyc(1, 1, 3'b000, 3, 3, 32'h40C, 0, 0, 1);
    cyc(1, 1, 3'b000, 3, 3, 32'h410, 0, 0, 1);
    idle(4);

    // Stalled branch evaluated once when the stall drops; stall inside shadow holds the window
    cyc(0, 0, 3'd0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 3'b110, 1, 9, 32'h500, 1, 0, 1);
    cyc(1, 1, 3'b110, 1, 9, 32'h500, 0, 0, 1);
    check("stall branch_cnt u0", 32'(bc0), 32'd1);
    cyc(1, 1, 3'b110, 1, 9, 32'h504, 1, 0, 1);
    cyc(1, 1, 3'b110, 1, 9, 32'h508, 0, 0, 1);
    cyc(1, 1, 3'b110, 1, 9, 32'h50C, 0, 0, 1);
    idle(4);

    // Illegal funct3 is sticky through legal branches
    cyc(1, 1, 3'b010, 1, 1, 32'h600, 0, 0, 1);
    cyc(1, 1, 3'b011, 1, 2, 32'h604, 0, 0, 1);
    cyc(1, 1, 3'b111, 9, 2, 32'h608, 0, 0, 1);
    idle(4);
    check("illegal sticky u0", 32'(illegal_w[0]), 32'd1);

    // Saturation: 17 taken branches
    cyc(0, 0, 3'd0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 17; k++) begin
      cyc(1, 1, 3'b100, 32'hFFFF_FFF0, 4, 32'h700 + 32'(k), 0, 0, 1);
      idle(3);
    end
    check("sat branch_cnt u0", 32'(bc0), 32'd15);
    check("sat taken_cnt u0",  32'(tc0), 32'd15);
    check("wide taken_cnt u1", 32'(tc1), 32'd17);
    cyc(1, 1, 3'b000, 8, 8, 32'h800, 0, 1, 1);
    check("clr priority branch_cnt u0", 32'(bc0), 32'd0);
    check("clr priority taken_cnt u1", 32'(tc1), 32'd0);

    // Reset mid-shadow, then immediate redirect
    idle(4);
    cyc(1, 1, 3'b001, 1, 2, 32'h900, 0, 0, 1);
    cyc(1, 1, 3'b001, 1, 2, 32'h904, 0, 0, 0);
    cyc(1, 1, 3'b001, 1, 2, 32'h908, 0, 0, 1);
    check("post reset taken_cnt u1", 32'(tc1), 32'd1);
    idle(4);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd1;
      b = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd1;
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
          a, b, $urandom(), $urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0,
          $urandom_range(0, 99) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
